load_align_unit: RTL
====================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter DMEM_AW, default 14, meaning data-memory word-address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock, and all state SHALL update on this edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  abandons the in-flight load.
REQ-005 SHALL have port req_valid  input  1  load request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-007 SHALL have port req_fnc  input  3  load funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_rd  input  5  destination register tag.
REQ-010 SHALL have port dmem_en  output  1  memory read strobe.
REQ-011 SHALL have port dmem_addr  output  DMEM_AW  word address.
REQ-012 SHALL have port dmem_dout  input  32  read data, valid one cycle after dmem_en.
REQ-013 SHALL have port rsp_valid  output  1  result available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port rsp_data  output  32  aligned and extended load data.
REQ-016 SHALL have port rsp_rd  output  5  tag captured at acceptance.
REQ-017 SHALL have port rsp_err  output  1  illegal or unsupported load.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT0, WAIT1 and RSP; req_ready SHALL equal (state==IDLE) && rst_n && !flush.
REQ-019 On acceptance at cycle T, SHALL drive dmem_en=1 and dmem_addr=req_addr[DMEM_AW+1:2] in T, register fnc/addr[1:0]/rd, and go to WAIT0.
REQ-020 In WAIT0, SHALL capture dmem_dout as lo; if the access crosses a word boundary, SHALL drive dmem_en=1 with dmem_addr=(word+1) mod 2^DMEM_AW and go to WAIT1, else go to RSP.
REQ-021 A crossing access SHALL be LH/LHU with addr[1:0]==3, or LW with addr[1:0]!=0.
REQ-022 In WAIT1, SHALL capture dmem_dout as hi and go to RSP.
REQ-023 Result SHALL be ({hi,lo} >> 8*addr[1:0]), truncated to 8 bits (LB/LBU), 16 bits (LH/LHU) or 32 bits (LW); LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; hi SHALL be 0 when not crossing.
REQ-024 rsp_data, rsp_rd and rsp_err SHALL be registered and stable while rsp_valid=1.
REQ-025 Latency SHALL be: non-crossing rsp_valid at T+2; crossing rsp_valid at T+3.
REQ-026 In RSP, rsp_valid SHALL be 1; on rsp_valid&&rsp_ready SHALL go to IDLE; no new request SHALL be accepted in that same cycle.
REQ-027 funct3 of 3, 6 or 7 SHALL issue no dmem read, go directly to RSP (rsp_valid at T+1) with rsp_err=1 and rsp_data=0.
REQ-028 flush SHALL force IDLE on the next edge from any state, deassert rsp_valid, and discard outstanding read data; flush together with req_valid in IDLE SHALL not accept the request.
REQ-029 dmem_en SHALL be 0 in every cycle not named in REQ-019/REQ-020.

Reset
REQ-030 While rst_n=0 at a clock edge, SHALL go to IDLE with rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, dmem_en=0, dmem_addr=0 and req_ready=0.
REQ-031 Reset mid-load SHALL drop the load without producing a response; the first acceptance SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-032 Macro MISALIGNED_LOAD_EN defined: crossing accesses SHALL be serviced per REQ-020..REQ-023.
REQ-033 Macro MISALIGNED_LOAD_EN undefined: crossing accesses SHALL issue no dmem read, go to RSP at T+1 with rsp_err=1 and rsp_data=0, and the WAIT1 state SHALL not exist.

Verification
REQ-034 mem[0]=0x8899AABB; LB at addr 0x1 with rsp_ready=1 -> rsp_valid at T+2, rsp_data=0xFFFFFFAA, rsp_err=0.
REQ-035 Same memory; LHU at 0x2 -> rsp_data=0x00008899; LH at 0x2 -> rsp_data=0xFFFF8899.
REQ-036 With MISALIGNED_LOAD_EN, mem[0]=0x44332211 and mem[1]=0x88776655; LW at 0x3 -> two dmem reads (word 0, then word 1), rsp_data=0x77665544 at T+3; without the macro -> rsp_err=1 at T+1 and no dmem_en after T.
REQ-037 funct3=7 at 0x0 -> dmem_en never asserted, rsp_err=1, rsp_data=0 at T+1.
REQ-038 LW issued, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable and req_ready=0 throughout; flush in WAIT0 -> rsp_valid never asserted and req_ready=1 the next cycle.
REQ-039 rst_n=0 driven in WAIT1 -> all outputs 0 next cycle; a request accepted after release completes normally.

Source files
------------

// File: rtl/load_align_unit.sv
// Load sequencer: issues one or two word reads, aligns and extends LB/LH/LW/LBU/LHU data.
// Define MISALIGNED_LOAD_EN to service word-crossing loads; otherwise they return rsp_err.
//
// state | meaning
// IDLE  | ready for a request
// WAIT0 | first read data arriving (lo word)
// WAIT1 | second read data arriving (hi word), only with MISALIGNED_LOAD_EN
// RSP   | result held until consumer accepts

module load_align_unit #(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_fnc,
    input  logic [31:0]        req_addr,
    input  logic [4:0]         req_rd,
    output logic               dmem_en,
    output logic [DMEM_AW-1:0] dmem_addr,
    input  logic [31:0]        dmem_dout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [4:0]         rsp_rd,
    output logic               rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT0,
`ifdef MISALIGNED_LOAD_EN
        WAIT1,
`endif
        RSP
    } state_t;

    function automatic logic is_bad_fnc(input logic [2:0] f);
        return (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
    endfunction

    function automatic logic crosses(input logic [2:0] f, input logic [1:0] off);
        return ((f[1:0] == 2'd1) && (off == 2'd3)) || ((f == 3'd2) && (off != 2'd0));
    endfunction

    function automatic logic [31:0] align(input logic [2:0] f, input logic [1:0] off,
                                          input logic [63:0] dw);
        logic [31:0] sh;
        sh = 32'(dw >> {off, 3'b000});
        case (f)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return sh;
            3'd4:    return {24'h0, sh[7:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    state_t             state, state_nxt;
    logic [2:0]         fnc_q;
    logic [1:0]         off_q;
    logic               accept;
    logic               req_bad;
    logic               rsp_load;
    logic [31:0]        rsp_data_nxt;
    logic               rsp_err_nxt;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:DMEM_AW+2];

`ifdef MISALIGNED_LOAD_EN
    logic [DMEM_AW-1:0] word_q;
    logic [31:0]        lo_q;
    assign req_bad = is_bad_fnc(req_fnc);
`else
    assign req_bad = is_bad_fnc(req_fnc) || crosses(req_fnc, req_addr[1:0]);
`endif

    assign req_ready = (state == IDLE) && rst_n && !flush;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RSP);

    always_comb begin
        state_nxt    = state;
        dmem_en      = 1'b0;
        dmem_addr    = '0;
        rsp_load     = 1'b0;
        rsp_data_nxt = 32'h0;
        rsp_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_nxt   = RSP;
                        rsp_load    = 1'b1;
                        rsp_err_nxt = 1'b1;
                    end else begin
                        dmem_en   = 1'b1;
                        dmem_addr = req_addr[DMEM_AW+1:2];
                        state_nxt = WAIT0;
                    end
                end
            end
            WAIT0: begin
`ifdef MISALIGNED_LOAD_EN
                if (crosses(fnc_q, off_q)) begin
                    dmem_en   = 1'b1;
                    dmem_addr = word_q + {{(DMEM_AW-1){1'b0}}, 1'b1};
                    state_nxt = WAIT1;
                end else begin
                    state_nxt    = RSP;
                    rsp_load     = 1'b1;
                    rsp_data_nxt = align(fnc_q, off_q, {32'h0, dmem_dout});
                end
`else
                state_nxt    = RSP;
                rsp_load     = 1'b1;
                rsp_data_nxt = align(fnc_q, off_q, {32'h0, dmem_dout});
`endif
            end
`ifdef MISALIGNED_LOAD_EN
            WAIT1: begin
                state_nxt    = RSP;
                rsp_load     = 1'b1;
                rsp_data_nxt = align(fnc_q, off_q, {dmem_dout, lo_q});
            end
`endif
            RSP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // flush and reset both kill any in-flight read and its result
        if (flush || !rst_n) begin
            state_nxt = IDLE;
            dmem_en   = 1'b0;
            dmem_addr = '0;
            rsp_load  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fnc_q    <= 3'd0;
            off_q    <= 2'd0;
            rsp_rd   <= 5'd0;
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
            word_q   <= '0;
            lo_q     <= 32'h0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                fnc_q  <= req_fnc;
                off_q  <= req_addr[1:0];
                rsp_rd <= req_rd;
`ifdef MISALIGNED_LOAD_EN
                word_q <= req_addr[DMEM_AW+1:2];
`endif
            end
`ifdef MISALIGNED_LOAD_EN
            if (state == WAIT0) lo_q <= dmem_dout;
`endif
            if (rsp_load) begin
                rsp_data <= rsp_data_nxt;
                rsp_err  <= rsp_err_nxt;
            end
        end
    end

endmodule
